// File: rtl/cv_ram_ctrl_if.sv
// cv_ram_ctrl_if: command-port bundle between the bus master and the RAM controller
//   S_EX_REQ/S_ADDR/S_CMD/S_D_WR : master -> controller request
//   S_EX_ACK/S_D_RD/BUSY         : controller -> master completion, read data, busy flag
interface cv_ram_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          S_EX_REQ;
    logic [AW-1:0] S_ADDR;
    logic [2:0]    S_CMD;
    logic [DW-1:0] S_D_WR;
    logic          S_EX_ACK;
    logic [DW-1:0] S_D_RD;
    logic          BUSY;

    modport slave (
        input  S_EX_REQ, S_ADDR, S_CMD, S_D_WR,
        output S_EX_ACK, S_D_RD, BUSY
    );

    modport master (
        output S_EX_REQ, S_ADDR, S_CMD, S_D_WR,
        input  S_EX_ACK, S_D_RD, BUSY
    );
endinterface

// File: rtl/cv_ram_ctrl.sv
// cv_ram_ctrl: dual-access RAM with a REQ/ACK command port, post-reset init sweep and fill
//   CLK, RST : clock, synchronous active-high reset
//   s        : command port (write / read / fill, registered ACK, BUSY)
//   ADDR     : datapath read address
//   DATA     : datapath read data, one-cycle latency, read-before-write
module cv_ram_ctrl #(
    parameter int            AW       = 5,
    parameter int            DW       = 8,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST,
    cv_ram_ctrl_if.slave  s,
    input  logic [AW-1:0] ADDR,
    output logic [DW-1:0] DATA
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {INIT, IDLE, RESP, FILL} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] rd_q, rd_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] mem [DEPTH];
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    assign s.S_EX_ACK = ack_q;
    assign s.S_D_RD   = rd_q;
    assign s.BUSY     = busy_q;
    assign DATA       = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        rd_d    = rd_q;
        fill_d  = fill_q;
        data_d  = mem[ADDR];
        we      = 1'b0;
        wa      = cnt_q;
        wd      = INIT_VAL;
        case (state_q)
            INIT: begin
                we    = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                if (s.S_EX_REQ) begin
                    case (s.S_CMD)
                        3'd1: begin
                            we      = 1'b1;
                            wa      = s.S_ADDR;
                            wd      = s.S_D_WR;
                            ack_d   = 1'b1;
                            state_d = RESP;
                        end
                        3'd2: begin
                            rd_d    = mem[s.S_ADDR];
                            ack_d   = 1'b1;
                            state_d = RESP;
                        end
                        3'd3: begin
                            fill_d  = s.S_D_WR;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = FILL;
                        end
                        default: begin
                            ack_d   = 1'b1;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            FILL: begin
                we    = 1'b1;
                wd    = fill_q;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            rd_q    <= '0;
            fill_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
        end
    end

    // Memory array has no reset; writes are suppressed while RST is high.
    always_ff @(posedge CLK) begin
        if (we && !RST) mem[wa] <= wd;
    end
endmodule

// File: tb/tb_cv_ram_ctrl.sv
// tb_cv_ram_ctrl: randomized self-checking bench for cv_ram_ctrl against an array model
module tb_cv_ram_ctrl;
    localparam int            AW    = 5;
    localparam int            DW    = 8;
    localparam int            DEPTH = 32;
    localparam logic [DW-1:0] IV    = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data;

    cv_ram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    cv_ram_ctrl #(.AW(AW), .DW(DW), .INIT_VAL(IV)) dut (
        .CLK  (clk),
        .RST  (rst),
        .s    (bus.slave),
        .ADDR (addr),
        .DATA (data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_rd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            addr = AW'(i);
            tick();
            vectors++;
            if (data !== ref_mem[i]) begin
                miscompares++;
                $display("FAIL %s addr %0d: DATA=%h expected %h", name, i, data, ref_mem[i]);
            end
        end
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        do begin
            tick();
            n++;
            vectors++;
            if (bus.S_EX_ACK !== 1'b0) begin
                miscompares++;
                $display("FAIL %s ack_during_init: ACK=%b expected 0", name, bus.S_EX_ACK);
            end
        end while (bus.BUSY !== 1'b0 && n < 100);
        vectors++;
        if (n != DEPTH) begin
            miscompares++;
            $display("FAIL %s busy_len: %0d cycles expected %0d", name, n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
    endtask

    task automatic do_cmd(input logic [2:0] cmd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string name);
        int n = 0;
        bus.S_EX_REQ = 1'b1;
        bus.S_CMD    = cmd;
        bus.S_ADDR   = a;
        bus.S_D_WR   = d;
        tick();
        bus.S_EX_REQ = 1'b0;
        if (cmd == 3'd3) begin
            vectors++;
            if (bus.S_EX_ACK !== 1'b0 || bus.BUSY !== 1'b1) begin
                miscompares++;
                $display("FAIL %s fill_start: ACK=%b BUSY=%b expected 0 1", name, bus.S_EX_ACK, bus.BUSY);
            end
            while (bus.S_EX_ACK !== 1'b1 && n < 100) begin
                bus.S_EX_REQ = 1'($urandom_range(0, 1));
                bus.S_CMD    = 3'($urandom_range(0, 7));
                bus.S_ADDR   = AW'($urandom);
                bus.S_D_WR   = DW'($urandom);
                tick();
                n++;
                if (bus.S_EX_ACK !== 1'b1) begin
                    vectors++;
                    if (bus.BUSY !== 1'b1) begin
                        miscompares++;
                        $display("FAIL %s fill_busy: BUSY=%b expected 1 at cycle %0d", name, bus.BUSY, n);
                    end
                end
            end
            bus.S_EX_REQ = 1'b0;
            vectors++;
            if (n != DEPTH || bus.BUSY !== 1'b0) begin
                miscompares++;
                $display("FAIL %s fill_len: ACK after %0d cycles BUSY=%b expected %0d 0", name, n, bus.BUSY, DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = d;
        end else begin
            if (cmd == 3'd2) ref_rd = ref_mem[a];
            if (cmd == 3'd1) ref_mem[a] = d;
            vectors++;
            if (bus.S_EX_ACK !== 1'b1 || bus.S_D_RD !== ref_rd) begin
                miscompares++;
                $display("FAIL %s resp: ACK=%b S_D_RD=%h expected 1 %h", name, bus.S_EX_ACK, bus.S_D_RD, ref_rd);
            end
        end
        tick();
        vectors++;
        if (bus.S_EX_ACK !== 1'b0 || bus.S_D_RD !== ref_rd) begin
            miscompares++;
            $display("FAIL %s after: ACK=%b S_D_RD=%h expected 0 %h", name, bus.S_EX_ACK, bus.S_D_RD, ref_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.S_EX_REQ = 1'b1;
        bus.S_CMD    = 3'd1;
        bus.S_ADDR   = 5'd5;
        bus.S_D_WR   = 8'hFF;
        tick();
        tick();
        vectors++;
        if (bus.BUSY !== 1'b1 || bus.S_EX_ACK !== 1'b0 || bus.S_D_RD !== 8'h00 || data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: BUSY=%b ACK=%b S_D_RD=%h DATA=%h expected 1 0 00 00",
                     bus.BUSY, bus.S_EX_ACK, bus.S_D_RD, data);
        end
        ref_rd = '0;
        rst = 1'b0;
        wait_init("reset");
        bus.S_EX_REQ = 1'b0;
        check_all("init_sweep");
    endtask

    task automatic test_write_read();
        do_cmd(3'd1, 5'd3, 8'h5C, "wr3");
        do_cmd(3'd2, 5'd3, 8'h00, "rd3");
        do_cmd(3'd1, 5'd4, 8'h99, "wr4");
        vectors++;
        if (bus.S_D_RD !== 8'h5C) begin
            miscompares++;
            $display("FAIL rd_hold: S_D_RD=%h expected 5c", bus.S_D_RD);
        end
    endtask

    task automatic test_held_req();
        logic [AW-1:0] a [6];
        logic [DW-1:0] d [6];
        int pulses = 0;
        for (int i = 0; i < 6; i++) begin
            a[i] = AW'($urandom);
            d[i] = DW'($urandom);
            bus.S_EX_REQ = 1'b1;
            bus.S_CMD    = 3'd1;
            bus.S_ADDR   = a[i];
            bus.S_D_WR   = d[i];
            tick();
            if (bus.S_EX_ACK === 1'b1) pulses++;
            vectors++;
            if (bus.S_EX_ACK !== 1'((i % 2) == 0)) begin
                miscompares++;
                $display("FAIL held_ack cycle %0d: ACK=%b expected %b", i, bus.S_EX_ACK, 1'((i % 2) == 0));
            end
            if (i % 2 == 0) ref_mem[a[i]] = d[i];
        end
        bus.S_EX_REQ = 1'b0;
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL held_pulses: %0d expected 3", pulses);
        end
        tick();
        check_all("held_mem");
        do_cmd(3'd6, AW'($urandom), DW'($urandom), "cmd6");
        check_all("cmd6_mem");
    endtask

    task automatic test_fill();
        do_cmd(3'd3, AW'($urandom), 8'h3C, "fill");
        check_all("fill_mem");
    endtask

    task automatic test_collision();
        do_cmd(3'd1, 5'd7, 8'h11, "col_pre");
        addr = 5'd7;
        bus.S_EX_REQ = 1'b1;
        bus.S_CMD    = 3'd1;
        bus.S_ADDR   = 5'd7;
        bus.S_D_WR   = 8'h22;
        tick();
        bus.S_EX_REQ = 1'b0;
        vectors++;
        if (data !== 8'h11) begin
            miscompares++;
            $display("FAIL collision_old: DATA=%h expected 11", data);
        end
        tick();
        vectors++;
        if (data !== 8'h22) begin
            miscompares++;
            $display("FAIL collision_new: DATA=%h expected 22", data);
        end
        ref_mem[7] = 8'h22;
    endtask

    task automatic test_random();
        logic [2:0] c;
        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom_range(0, 7));
            if (c == 3'd3) c = 3'd2;
            do_cmd(c, AW'($urandom), DW'($urandom), "random");
        end
        check_all("random_mem");
    endtask

    task automatic test_reset_mid_fill();
        bus.S_EX_REQ = 1'b1;
        bus.S_CMD    = 3'd3;
        bus.S_D_WR   = 8'h77;
        tick();
        bus.S_EX_REQ = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (bus.S_EX_ACK !== 1'b0) begin
                miscompares++;
                $display("FAIL midfill_ack cycle %0d: ACK=%b expected 0", i, bus.S_EX_ACK);
            end
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.S_EX_ACK !== 1'b0 || bus.BUSY !== 1'b1 || bus.S_D_RD !== 8'h00 || data !== 8'h00) begin
            miscompares++;
            $display("FAIL midfill_reset: ACK=%b BUSY=%b S_D_RD=%h DATA=%h expected 0 1 00 00",
                     bus.S_EX_ACK, bus.BUSY, bus.S_D_RD, data);
        end
        ref_rd = '0;
        rst = 1'b0;
        wait_init("midfill");
        check_all("midfill_mem");
    endtask

    initial begin
        bus.S_EX_REQ = 1'b0;
        bus.S_CMD    = 3'd0;
        bus.S_ADDR   = '0;
        bus.S_D_WR   = '0;
        test_reset();
        test_write_read();
        test_held_req();
        test_fill();
        test_collision();
        test_random();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cv_ram_ctrl.md
Name: cv_ram_ctrl

Overview:
- Parametrised dual-access RAM. A slave command port performs write, read and whole-array fill with a registered REQ/ACK handshake.
- An independent registered read port feeds the datapath.
- After reset, an automatic init sweep loads INIT_VAL into every location.
- Sits where the command processor's data/program RAM lives; the bus master drives the S_* port and the execution unit drives ADDR/DATA.

Parameters:
AW, 5, address width; DEPTH = 2**AW
DW, 8, data width
INIT_VAL, 0, DW-bit value written to every word by the post-reset sweep

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
S_EX_REQ  in  1  command request; master holds it until S_EX_ACK is seen
S_ADDR  in  AW  command address
S_CMD  in  3  0 NOP, 1 WRITE, 2 READ, 3 FILL, 4-7 NOP
S_D_WR  in  DW  write/fill data
S_EX_ACK  out  1  one-cycle completion pulse, registered
S_D_RD  out  DW  read data, valid while S_EX_ACK=1 after READ, then held
BUSY  out  1  high during init sweep and fill
ADDR  in  AW  datapath read address
DATA  out  DW  datapath read data, 1-cycle latency

Behaviour:
- Reset (edge with RST=1):
  - state<=INIT, cnt<=0, S_EX_ACK<=0, S_D_RD<=0, DATA<=0, BUSY<=1.
  - No memory write occurs while RST=1.
  - Reset in any state, including mid-FILL or RESP, aborts the operation with no ACK.
- States: INIT, IDLE, RESP, FILL.
- INIT:
  - Each edge with RST=0: mem[cnt]<=INIT_VAL, cnt++.
  - On the edge writing DEPTH-1: state<=IDLE, BUSY<=0.
  - BUSY is therefore high for DEPTH cycles after RST deasserts.
  - S_EX_REQ is ignored (no ACK).
- IDLE, acceptance edge E0 when S_EX_REQ=1:
  - WRITE: mem[S_ADDR]<=S_D_WR; S_EX_ACK<=1; state<=RESP.
  - READ: S_D_RD<=mem[S_ADDR] (value before any same-edge write); S_EX_ACK<=1; state<=RESP.
  - NOP/unsupported: no memory effect; S_EX_ACK<=1; state<=RESP.
  - FILL: latch S_D_WR; cnt<=0; BUSY<=1; state<=FILL.
- FILL:
  - Each edge writes mem[cnt]<=latched data, cnt++. The writes occupy edges E1..E_DEPTH.
  - On edge E_DEPTH: S_EX_ACK<=1, BUSY<=0, state<=RESP.
  - S_ADDR, S_D_WR and S_CMD changes during FILL are ignored.
- RESP:
  - S_EX_ACK is high for exactly this cycle. Next edge: S_EX_ACK<=0, state<=IDLE.
  - S_EX_REQ is not sampled in RESP. A REQ held continuously is therefore re-accepted at E0+2, so the minimum period is 2 cycles per WRITE/READ.
- S_D_RD changes only on READ acceptance; it holds its value across WRITE, FILL and NOP.
- Datapath port:
  - Every edge with RST=0: DATA<=mem[ADDR], in all states including INIT and FILL.
  - Same-edge collision with a slave/init/fill write to the same address returns the old word (read-before-write); the new word appears one edge later.
- cnt is AW+1 bits or compared against DEPTH-1; there is no wrap past DEPTH-1.
- S_CMD is decoded on the full 3 bits; there is no partial decode.

Test Plan:
- Reset/init (AW=5, INIT_VAL=8'hA5): pulse RST for 2 cycles, then read ADDR 0..31 after BUSY falls -> BUSY high for exactly 32 cycles after RST low; every DATA=A5; no S_EX_ACK while REQ=1 during INIT.
- Write/read handshake: WRITE addr 3, data 8'h5C -> S_EX_ACK one cycle after E0 for 1 cycle. Then READ addr 3 -> S_EX_ACK + S_D_RD=5C at E0+1. S_D_RD still 5C after a subsequent WRITE to addr 4.
- Held REQ: REQ held high with WRITE for 6 cycles -> exactly 3 ACK pulses at cycles 1,3,5 with addresses sampled at 0,2,4; cmd 6 -> ACK with memory unchanged.
- Fill: FILL with data 8'h3C -> BUSY high 32 cycles, S_EX_ACK on edge E32; all 32 words read 3C; S_ADDR/S_D_WR toggled during the fill have no effect.
- Collision: port ADDR=7 in the same cycle as WRITE addr 7 from 11 to 22 -> DATA=11 next cycle, DATA=22 the cycle after.
- Reset mid-fill at cnt=10: no ACK; init sweep restarts; words 0..31 read INIT_VAL after BUSY falls.
